// File: rtl/mem_tag_access_stage.sv
// Memory tag-access stage: registers one lane of execution-stage output,
// applies selective flush, consumes the D-cache tag-hit result, decides
// replay and raises MSHR allocation requests on load misses.
module mem_tag_access_stage #(
  parameter int PADDR_W   = 32,
  parameter int DATA_W    = 32,
  parameter int AL_IDX_W  = 6,
  parameter int MSHR_ID_W = 2,
  parameter int CNT_W     = 16,
  parameter int COOLDOWN  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 clear,
  input  logic                 toRecoveryPhase,
  input  logic [AL_IDX_W-1:0]  flushRangeHeadPtr,
  input  logic [AL_IDX_W-1:0]  flushRangeTailPtr,
  input  logic                 inValid,
  input  logic                 inIsLoad,
  input  logic                 inIsStore,
  input  logic                 inRegValid,
  input  logic                 inUncachable,
  input  logic                 inHasAllocatedMSHR,
  input  logic [PADDR_W-1:0]   inPhyAddr,
  input  logic [DATA_W-1:0]    inData,
  input  logic [AL_IDX_W-1:0]  inActiveListPtr,
  input  logic                 dcHit,
  output logic                 mshrAllocReq,
  input  logic                 mshrAllocAck,
  input  logic [MSHR_ID_W-1:0] mshrAllocId,
  output logic                 outValid,
  output logic                 outReplay,
  output logic                 outMSHRValid,
  output logic [MSHR_ID_W-1:0] outMSHRId,
  output logic [PADDR_W-1:0]   outPhyAddr,
  output logic [DATA_W-1:0]    outData,
  output logic [AL_IDX_W-1:0]  outActiveListPtr,
  output logic [CNT_W-1:0]     allocCount
);

  // Cooldown counter must hold COOLDOWN; keep at least one bit when disabled.
  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  logic                valid_q, valid_d;
  logic                is_load_q, is_load_d;
  logic                reg_valid_q, reg_valid_d;
  logic                uncach_q, uncach_d;
  logic                has_mshr_q, has_mshr_d;
  logic [PADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [AL_IDX_W-1:0] al_ptr_q, al_ptr_d;
  logic [CD_W-1:0]     cooldown_q, cooldown_d;
  logic [CNT_W-1:0]    alloc_cnt_q, alloc_cnt_d;

  logic flush_hit_s;
  logic live_s;
  logic need_miss_s;
  logic req_s;
  logic grant_s;

  // Store-ness never changes the outcome: a store replays only on invalid
  // operands, which the shared operand-valid bit already covers.
  logic unused_store_s;
  assign unused_store_s = inIsStore;

  // Stage register next-state: capture when not stalled, otherwise hold.
  always_comb begin
    valid_d     = valid_q;
    is_load_d   = is_load_q;
    reg_valid_d = reg_valid_q;
    uncach_d    = uncach_q;
    has_mshr_d  = has_mshr_q;
    paddr_d     = paddr_q;
    data_d      = data_q;
    al_ptr_d    = al_ptr_q;
    if (!stall) begin
      valid_d     = inValid;
      is_load_d   = inIsLoad;
      reg_valid_d = inRegValid;
      uncach_d    = inUncachable;
      has_mshr_d  = inHasAllocatedMSHR;
      paddr_d     = inPhyAddr;
      data_d      = inData;
      al_ptr_d    = inActiveListPtr;
    end else begin
      valid_d     = valid_q;
    end
  end

  // Selective flush: does the held op's pointer fall inside [head, tail)?
  always_comb begin
    flush_hit_s = 1'b0;
    if (!toRecoveryPhase) begin
      flush_hit_s = 1'b0;
    end else if (flushRangeHeadPtr < flushRangeTailPtr) begin
      flush_hit_s = (al_ptr_q >= flushRangeHeadPtr) && (al_ptr_q < flushRangeTailPtr);
    end else if (flushRangeHeadPtr > flushRangeTailPtr) begin
      flush_hit_s = (al_ptr_q >= flushRangeHeadPtr) || (al_ptr_q < flushRangeTailPtr);
    end else begin
      // Equal head and tail means the whole window is being flushed.
      flush_hit_s = 1'b1;
    end
  end

  // Liveness, miss detection, MSHR request/grant and replay decision.
  always_comb begin
    live_s      = valid_q && !stall && !clear && !rst && !flush_hit_s;
    need_miss_s = is_load_q && (!dcHit || uncach_q);
    req_s       = live_s && is_load_q && reg_valid_q && need_miss_s &&
                  !has_mshr_q && (cooldown_q == {CD_W{1'b0}});
    grant_s     = req_s && mshrAllocAck;
    outReplay   = 1'b0;
    if (!live_s) begin
      outReplay = 1'b0;
    end else if (!reg_valid_q) begin
      outReplay = 1'b1;
    end else if (need_miss_s) begin
      // Every missing load replays, whether it got, was refused or already owns an MSHR.
      outReplay = 1'b1;
    end else begin
      outReplay = 1'b0;
    end
  end

  // Output drive: pass-through fields and grant reporting.
  always_comb begin
    outValid         = live_s;
    mshrAllocReq     = req_s;
    outMSHRValid     = grant_s;
    outMSHRId        = {MSHR_ID_W{1'b0}};
    if (grant_s) begin
      outMSHRId = mshrAllocId;
    end else begin
      outMSHRId = {MSHR_ID_W{1'b0}};
    end
    outPhyAddr       = paddr_q;
    outData          = data_q;
    outActiveListPtr = al_ptr_q;
    allocCount       = alloc_cnt_q;
  end

  // Cooldown and saturating grant counter next-state; both run through stalls.
  always_comb begin
    cooldown_d  = cooldown_q;
    alloc_cnt_d = alloc_cnt_q;
    if (grant_s) begin
      cooldown_d = CD_W'(COOLDOWN);
    end else if (cooldown_q != {CD_W{1'b0}}) begin
      cooldown_d = cooldown_q - {{(CD_W-1){1'b0}}, 1'b1};
    end else begin
      cooldown_d = {CD_W{1'b0}};
    end
    if (grant_s && (alloc_cnt_q != {CNT_W{1'b1}})) begin
      alloc_cnt_d = alloc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      alloc_cnt_d = alloc_cnt_q;
    end
  end

  // State registers with synchronous reset; data fields zeroed for determinism.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      is_load_q   <= 1'b0;
      reg_valid_q <= 1'b0;
      uncach_q    <= 1'b0;
      has_mshr_q  <= 1'b0;
      paddr_q     <= {PADDR_W{1'b0}};
      data_q      <= {DATA_W{1'b0}};
      al_ptr_q    <= {AL_IDX_W{1'b0}};
      cooldown_q  <= {CD_W{1'b0}};
      alloc_cnt_q <= {CNT_W{1'b0}};
    end else begin
      valid_q     <= valid_d;
      is_load_q   <= is_load_d;
      reg_valid_q <= reg_valid_d;
      uncach_q    <= uncach_d;
      has_mshr_q  <= has_mshr_d;
      paddr_q     <= paddr_d;
      data_q      <= data_d;
      al_ptr_q    <= al_ptr_d;
      cooldown_q  <= cooldown_d;
      alloc_cnt_q <= alloc_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_tag_access_stage.sv
// Scoreboard testbench for mem_tag_access_stage: a stimulus process drives
// each cycle and pushes the reference model's expected outputs; a monitor
// pops and compares on the falling edge.
module tb_mem_tag_access_stage;
  localparam int PADDR_W   = 32;
  localparam int DATA_W    = 32;
  localparam int AL_IDX_W  = 6;
  localparam int MSHR_ID_W = 2;
  localparam int CNT_W     = 4;
  localparam int COOLDOWN  = 2;
  localparam int AL_SIZE   = 1 << AL_IDX_W;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, stall, clear, toRecoveryPhase;
  logic [AL_IDX_W-1:0]  flushRangeHeadPtr, flushRangeTailPtr;
  logic                 inValid, inIsLoad, inIsStore, inRegValid, inUncachable, inHasAllocatedMSHR;
  logic [PADDR_W-1:0]   inPhyAddr;
  logic [DATA_W-1:0]    inData;
  logic [AL_IDX_W-1:0]  inActiveListPtr;
  logic                 dcHit, mshrAllocReq, mshrAllocAck;
  logic [MSHR_ID_W-1:0] mshrAllocId;
  logic                 outValid, outReplay, outMSHRValid;
  logic [MSHR_ID_W-1:0] outMSHRId;
  logic [PADDR_W-1:0]   outPhyAddr;
  logic [DATA_W-1:0]    outData;
  logic [AL_IDX_W-1:0]  outActiveListPtr;
  logic [CNT_W-1:0]     allocCount;

  mem_tag_access_stage #(
    .PADDR_W(PADDR_W), .DATA_W(DATA_W), .AL_IDX_W(AL_IDX_W),
    .MSHR_ID_W(MSHR_ID_W), .CNT_W(CNT_W), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .clear(clear),
    .toRecoveryPhase(toRecoveryPhase),
    .flushRangeHeadPtr(flushRangeHeadPtr), .flushRangeTailPtr(flushRangeTailPtr),
    .inValid(inValid), .inIsLoad(inIsLoad), .inIsStore(inIsStore),
    .inRegValid(inRegValid), .inUncachable(inUncachable),
    .inHasAllocatedMSHR(inHasAllocatedMSHR),
    .inPhyAddr(inPhyAddr), .inData(inData), .inActiveListPtr(inActiveListPtr),
    .dcHit(dcHit), .mshrAllocReq(mshrAllocReq), .mshrAllocAck(mshrAllocAck),
    .mshrAllocId(mshrAllocId), .outValid(outValid), .outReplay(outReplay),
    .outMSHRValid(outMSHRValid), .outMSHRId(outMSHRId), .outPhyAddr(outPhyAddr),
    .outData(outData), .outActiveListPtr(outActiveListPtr), .allocCount(allocCount)
  );

  typedef struct {
    int                   cyc;
    logic                 valid, replay, req, mv;
    logic [MSHR_ID_W-1:0] id;
    logic [PADDR_W-1:0]   addr;
    logic [DATA_W-1:0]    data;
    logic [AL_IDX_W-1:0]  ptr;
    logic [CNT_W-1:0]     cnt;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: the op currently held in the stage, grant history.
  bit                  m_valid = 1'b0, m_load = 1'b0, m_rv = 1'b0, m_unc = 1'b0, m_has = 1'b0;
  logic [PADDR_W-1:0]  m_addr = '0;
  logic [DATA_W-1:0]   m_data = '0;
  logic [AL_IDX_W-1:0] m_ptr = '0;
  int                  m_count = 0;
  int                  m_last_grant = -100;
  int                  cyc = 0;

  // Pointer lies in the circular window starting at head and ending before tail.
  function automatic bit in_window(int head, int tail, int ptr);
    int span, off;
    if (head == tail) return 1'b1;
    span = (tail - head + AL_SIZE) % AL_SIZE;
    off  = (ptr - head + AL_SIZE) % AL_SIZE;
    return off < span;
  endfunction

  function automatic void chk(string name, int c, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, exp);
    end
  endfunction

  // One clock cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input bit r, s, c, fr, input logic [AL_IDX_W-1:0] head, tail,
                      input bit v, ld, st, rv, un, hs,
                      input logic [PADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [AL_IDX_W-1:0] p, input bit dc, ak,
                      input logic [MSHR_ID_W-1:0] aid);
    exp_t e;
    bit flush, live, need, req, mv;
    @(posedge clk);
    #1;
    rst = r; stall = s; clear = c; toRecoveryPhase = fr;
    flushRangeHeadPtr = head; flushRangeTailPtr = tail;
    inValid = v; inIsLoad = ld; inIsStore = st; inRegValid = rv;
    inUncachable = un; inHasAllocatedMSHR = hs;
    inPhyAddr = a; inData = d; inActiveListPtr = p;
    dcHit = dc; mshrAllocAck = ak; mshrAllocId = aid;

    flush = fr && in_window(int'(head), int'(tail), int'(m_ptr));
    live  = m_valid && !s && !c && !r && !flush;
    need  = m_load && (!dc || m_unc);
    req   = live && m_rv && need && !m_has && ((cyc - m_last_grant) > COOLDOWN);
    mv    = req && ak;
    e.cyc    = cyc;
    e.valid  = live;
    e.replay = live && (!m_rv || need);
    e.req    = req;
    e.mv     = mv;
    e.id     = mv ? aid : '0;
    e.addr   = m_addr;
    e.data   = m_data;
    e.ptr    = m_ptr;
    e.cnt    = CNT_W'(m_count);
    sb.push_back(e);

    if (r) begin
      m_valid = 1'b0; m_load = 1'b0; m_rv = 1'b0; m_unc = 1'b0; m_has = 1'b0;
      m_addr = '0; m_data = '0; m_ptr = '0;
      m_count = 0; m_last_grant = -100;
    end else begin
      if (mv) begin
        m_count      = (m_count >= CNT_MAX) ? CNT_MAX : m_count + 1;
        m_last_grant = cyc;
      end
      if (!s) begin
        m_valid = v; m_load = ld; m_rv = rv; m_unc = un; m_has = hs;
        m_addr = a; m_data = d; m_ptr = p;
      end
    end
    cyc++;
  endtask

  task automatic load_op(input logic [AL_IDX_W-1:0] p, input bit hs, dc, ak,
                         input logic [MSHR_ID_W-1:0] aid);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, hs,
         $urandom, $urandom, p, dc, ak, aid);
  endtask

  task automatic idle(input bit dc, ak, input logic [MSHR_ID_W-1:0] aid);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         '0, '0, '0, dc, ak, aid);
  endtask

  task automatic rand_step();
    bit ld;
    ld = ($urandom_range(0, 99) < 70);
    step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 15,
         $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 15,
         AL_IDX_W'($urandom), AL_IDX_W'($urandom),
         $urandom_range(0, 99) < 80, ld, !ld,
         $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 15,
         $urandom_range(0, 99) < 15, $urandom, $urandom,
         AL_IDX_W'($urandom), $urandom_range(0, 1) == 1,
         $urandom_range(0, 99) < 70, MSHR_ID_W'($urandom));
  endtask

  // Monitor: compare the DUT against the oldest pending expectation each cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("outValid",         e.cyc, 64'(outValid),         64'(e.valid));
        chk("outReplay",        e.cyc, 64'(outReplay),        64'(e.replay));
        chk("mshrAllocReq",     e.cyc, 64'(mshrAllocReq),     64'(e.req));
        chk("outMSHRValid",     e.cyc, 64'(outMSHRValid),     64'(e.mv));
        chk("outMSHRId",        e.cyc, 64'(outMSHRId),        64'(e.id));
        chk("outPhyAddr",       e.cyc, 64'(outPhyAddr),       64'(e.addr));
        chk("outData",          e.cyc, 64'(outData),          64'(e.data));
        chk("outActiveListPtr", e.cyc, 64'(outActiveListPtr), 64'(e.ptr));
        chk("allocCount",       e.cyc, 64'(allocCount),       64'(e.cnt));
      end
    end
  end

  initial begin : stimulus
    int guard;
    rst = 1'b1; stall = 1'b0; clear = 1'b0; toRecoveryPhase = 1'b0;
    flushRangeHeadPtr = '0; flushRangeTailPtr = '0;
    inValid = 1'b0; inIsLoad = 1'b0; inIsStore = 1'b0; inRegValid = 1'b0;
    inUncachable = 1'b0; inHasAllocatedMSHR = 1'b0;
    inPhyAddr = '0; inData = '0; inActiveListPtr = '0;
    dcHit = 1'b0; mshrAllocAck = 1'b0; mshrAllocId = '0;

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    idle(1'b0, 1'b0, '0);

    // Cacheable load hit.
    load_op(6'd5, 1'b0, 1'b0, 1'b0, '0);
    // First miss granted with id 2, second miss one cycle later is cooling down.
    load_op(6'd6, 1'b0, 1'b1, 1'b0, '0);
    load_op(6'd7, 1'b0, 1'b0, 1'b1, 2'd2);
    idle(1'b0, 1'b1, 2'd1);
    // Load owning an MSHR: miss replays without a request, then hits.
    load_op(6'd8, 1'b1, 1'b0, 1'b1, 2'd3);
    load_op(6'd8, 1'b1, 1'b0, 1'b1, 2'd3);
    idle(1'b1, 1'b1, '0);
    // Wrap-around flush window 60..2.
    load_op(6'd1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd60, 6'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
         32'h1000_0010, 32'h0, 6'd10, 1'b0, 1'b1, 2'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd60, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         '0, '0, '0, 1'b1, 1'b0, '0);
    // Stall for three cycles with a new op waiting.
    load_op(6'd20, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
           32'hABCD_0000, 32'h5555_AAAA, 6'd21, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
         32'hABCD_0000, 32'h5555_AAAA, 6'd21, 1'b1, 1'b0, '0);
    idle(1'b1, 1'b0, '0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) rand_step();

    // Drive the counter into saturation with back-to-back granted misses.
    for (int i = 0; i < 60; i++) load_op(AL_IDX_W'(i), 1'b0, 1'b0, 1'b1, MSHR_ID_W'(i));
    idle(1'b0, 1'b0, '0);
    chk("alloc_saturated", cyc, 64'(allocCount), 64'(CNT_MAX));

    // Reset in the middle of a stream of misses.
    load_op(6'd33, 1'b0, 1'b0, 1'b1, 2'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
         32'hFFFF_0000, 32'h1, 6'd34, 1'b0, 1'b1, 2'd1);
    load_op(6'd35, 1'b0, 1'b0, 1'b1, 2'd1);
    chk("alloc_after_reset", cyc, 64'(allocCount), 64'd0);
    idle(1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 200; i++) rand_step();

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_tag_access_stage.md
Name: mem_tag_access_stage

Overview:
- Memory-pipeline stage directly downstream of the memory execution stage, one lane per instance.
- Registers the execution stage's output (valid, physical address, store data, active-list pointer, flags) and applies selective flush.
- Consumes the D-cache tag-hit result for the load issued in the previous stage, decides replay, and allocates an MSHR on a load miss or uncachable load.
- Drives the pipeline register input of the register-write stage and keeps a saturating MSHR-allocation counter.

Parameters:
- PADDR_W, 32, physical address width
- DATA_W, 32, data width
- AL_IDX_W, 6, active-list pointer width
- MSHR_ID_W, 2, MSHR index width
- CNT_W, 16, allocation counter width
- COOLDOWN, 2, cycles after an MSHR grant during which no new allocation request is raised (0 disables)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  back-end stall; stage register holds
- clear  in  1  back-end clear; outputs invalid this cycle
- toRecoveryPhase  in  1  selective flush active
- flushRangeHeadPtr  in  AL_IDX_W  flush range head (inclusive)
- flushRangeTailPtr  in  AL_IDX_W  flush range tail (exclusive)
- inValid  in  1  op valid from execution stage
- inIsLoad  in  1  op is a load
- inIsStore  in  1  op is a store
- inRegValid  in  1  source operands were valid
- inUncachable  in  1  address is uncachable
- inHasAllocatedMSHR  in  1  op already owns an MSHR
- inPhyAddr  in  PADDR_W  physical address
- inData  in  DATA_W  store data / CSR read data
- inActiveListPtr  in  AL_IDX_W  active-list pointer
- dcHit  in  1  tag hit for the load now in this stage
- mshrAllocReq  out  1  MSHR allocation request
- mshrAllocAck  in  1  same-cycle grant
- mshrAllocId  in  MSHR_ID_W  granted index
- outValid  out  1  op valid to next stage
- outReplay  out  1  op must be replayed
- outMSHRValid  out  1  op owns an MSHR granted this cycle
- outMSHRId  out  MSHR_ID_W  granted MSHR index
- outPhyAddr  out  PADDR_W  registered address
- outData  out  DATA_W  registered data
- outActiveListPtr  out  AL_IDX_W  registered pointer
- allocCount  out  CNT_W  saturating count of MSHR grants

Behaviour:
- Stage register:
  - rst clears the valid bit, the cooldown counter and allocCount.
  - Otherwise, when !stall, all in* signals are captured.
  - When stall, the register holds.
  - The data fields are don't-care after reset but must be deterministic (zeroed).
- Latency: one cycle from in* to out*. All out* are combinational from the stage register plus dcHit and mshrAllocAck.
- Flush: flushHit = toRecoveryPhase && ptr in range.
  - head < tail: head <= ptr < tail.
  - head > tail (wrap): ptr >= head or ptr < tail.
  - head == tail: every ptr is flushed.
- Liveness: live = regValid && !stall && !clear && !rst && !flushHit.
- outValid = live. outPhyAddr, outData and outActiveListPtr pass through unconditionally.
- needMiss = isLoad && (!dcHit || uncachable).
- mshrAllocReq = live && isLoad && regRegValid && needMiss && !regHasAllocatedMSHR && cooldown == 0.
- outMSHRValid = mshrAllocReq && mshrAllocAck. outMSHRId = mshrAllocId when outMSHRValid, else 0.
- Replay decision, evaluated in this order; only meaningful when live, forced 0 when !live:
  - !regRegValid -> 1.
  - load && needMiss -> 1 (granted, refused or cooling down; a load already owning an MSHR also replays until a hit).
  - Otherwise 0.
  - A store replays only on !regRegValid. dcHit is ignored for stores.
- Cooldown counter: loads COOLDOWN on a grant, otherwise decrements toward 0 every cycle, including during stall. Reset value 0.
- allocCount: +1 per grant, saturates at all-ones, not affected by clear.
- Reset mid-operation: the first cycle after rst deasserts has outValid = 0 and mshrAllocReq = 0.
- Flush or clear suppresses mshrAllocReq, so no MSHR is leaked.
- Reset values: all outputs 0.

Test Plan:
- Cacheable load, inRegValid = 1, dcHit = 1 -> next cycle outValid = 1, outReplay = 0, mshrAllocReq = 0.
- Load miss, dcHit = 0, mshrAllocAck = 1, mshrAllocId = 2 -> outMSHRValid = 1, outMSHRId = 2, outReplay = 1, allocCount 0 -> 1. A second miss the next cycle sees mshrAllocReq = 0 (COOLDOWN = 2) and outReplay = 1.
- Load miss with inHasAllocatedMSHR = 1 -> mshrAllocReq = 0, outReplay = 1. The same op with dcHit = 1 -> outReplay = 0.
- Wrap flush: head = 60, tail = 3, ptr = 1 -> outValid = 0, mshrAllocReq = 0. ptr = 10 -> outValid = 1.
- stall held 3 cycles with new inputs -> register holds the original ptr and outValid = 0. On release the original op is presented, then the new one.
- Force allocCount to all-ones via repeated grants (CNT_W = 4, COOLDOWN = 0, 17 grants) -> allocCount stays 15. rst mid-stream -> allocCount = 0 and outValid = 0.
